// File: rtl/acc_ctrl_sequencer.sv
// rtl/acc_ctrl_sequencer.sv - fetch/decode/execute microsequencer for the 8-bit accumulator machine
module acc_ctrl_sequencer #(
  parameter int OPC_W = 4,
  parameter int ST_W  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             prog_mode,
  input  logic             prog_strobe,
  input  logic [OPC_W-1:0] opcode,
  input  logic             acc_zero,
  output logic             pc_oe,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_we,
  output logic             ram_oe,
  output logic             ram_we,
  output logic             ir_we,
  output logic             ir_oe,
  output logic             breg_we,
  output logic             alu_oe,
  output logic             alu_sub,
  output logic             acc_oe,
  output logic             acc_we,
  output logic             acc_load,
  output logic             out_we,
  output logic             halted,
  output logic [ST_W-1:0]  state
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    PROG = 4'd1,
    F1   = 4'd2,
    F2   = 4'd3,
    DEC  = 4'd4,
    E1   = 4'd5,
    E2   = 4'd6,
    E3   = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  state_t           end_st;

  assign end_st = run ? F1 : IDLE;

  always_comb begin
    state_d = IDLE;
    opc_d   = opc_q;
    case (state_q)
      IDLE: begin
        if (prog_mode)  state_d = PROG;
        else if (run)   state_d = F1;
        else            state_d = IDLE;
      end
      PROG: state_d = prog_mode ? PROG : IDLE;
      F1:   state_d = F2;
      F2:   state_d = DEC;
      DEC: begin
        opc_d = opcode;
        if (opcode == OP_HLT)
          state_d = HALT;
        else if (opcode >= OP_LDA && opcode <= OP_OUT)
          state_d = E1;
        else
          state_d = end_st;
      end
      E1: begin
        case (opc_q)
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_OUT: state_d = E2;
          default:                                state_d = end_st;
        endcase
      end
      E2:   state_d = (opc_q == OP_ADD || opc_q == OP_SUB) ? E3 : end_st;
      E3:   state_d = end_st;
      HALT: state_d = run ? HALT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Strobes depend only on registered state/opcode, except the programmer
  // load and the JZ branch condition which must react in the same cycle.
  always_comb begin
    pc_oe    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_we   = 1'b0;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    ir_we    = 1'b0;
    ir_oe    = 1'b0;
    breg_we  = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    acc_oe   = 1'b0;
    acc_we   = 1'b0;
    acc_load = 1'b0;
    out_we   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      PROG: acc_load = prog_strobe;
      F1: begin
        pc_oe  = 1'b1;
        mar_we = 1'b1;
      end
      F2: begin
        ram_oe = 1'b1;
        ir_we  = 1'b1;
        pc_inc = 1'b1;
      end
      E1: begin
        case (opc_q)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_oe  = 1'b1;
            mar_we = 1'b1;
          end
          OP_STA: begin
            ir_oe  = 1'b1;
            mar_we = 1'b1;
            acc_oe = 1'b1;
          end
          OP_JMP: begin
            ir_oe   = 1'b1;
            pc_load = 1'b1;
          end
          OP_JZ: begin
            ir_oe   = 1'b1;
            pc_load = acc_zero;
          end
          OP_OUT: acc_oe = 1'b1;
          default: ;
        endcase
      end
      E2: begin
        case (opc_q)
          OP_LDA: begin
            ram_oe = 1'b1;
            acc_we = 1'b1;
          end
          OP_STA: ram_we = 1'b1;
          OP_ADD, OP_SUB: begin
            ram_oe  = 1'b1;
            breg_we = 1'b1;
          end
          OP_OUT: out_we = 1'b1;
          default: ;
        endcase
      end
      E3: begin
        if (opc_q == OP_ADD || opc_q == OP_SUB) begin
          alu_oe  = 1'b1;
          acc_we  = 1'b1;
          alu_sub = (opc_q == OP_SUB);
        end
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = ST_W'(state_q);

endmodule

// File: tb/tb_acc_ctrl_sequencer.sv
// tb/tb_acc_ctrl_sequencer.sv - table-driven scoreboard bench for acc_ctrl_sequencer
module tb_acc_ctrl_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, run, prog_mode, prog_strobe, acc_zero;
  logic [3:0] opcode;
  logic       pc_oe, pc_inc, pc_load, mar_we, ram_oe, ram_we, ir_we, ir_oe, breg_we;
  logic       alu_oe, alu_sub, acc_oe, acc_we, acc_load, out_we, halted;
  logic [3:0] state;

  acc_ctrl_sequencer #(.OPC_W(4), .ST_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .run(run), .prog_mode(prog_mode), .prog_strobe(prog_strobe),
    .opcode(opcode), .acc_zero(acc_zero), .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_load(pc_load),
    .mar_we(mar_we), .ram_oe(ram_oe), .ram_we(ram_we), .ir_we(ir_we), .ir_oe(ir_oe),
    .breg_we(breg_we), .alu_oe(alu_oe), .alu_sub(alu_sub), .acc_oe(acc_oe), .acc_we(acc_we),
    .acc_load(acc_load), .out_we(out_we), .halted(halted), .state(state)
  );

  always #5 CLK = ~CLK;

  localparam logic [15:0] PC_OE = 16'h8000, PC_INC = 16'h4000, PC_LOAD = 16'h2000;
  localparam logic [15:0] MAR_WE = 16'h1000, RAM_OE = 16'h0800, RAM_WE = 16'h0400;
  localparam logic [15:0] IR_WE = 16'h0200, IR_OE = 16'h0100, BREG_WE = 16'h0080;
  localparam logic [15:0] ALU_OE = 16'h0040, ALU_SUB = 16'h0020, ACC_OE = 16'h0010;
  localparam logic [15:0] ACC_WE = 16'h0008, ACC_LOAD = 16'h0004, OUT_WE = 16'h0002;
  localparam logic [15:0] HALTED = 16'h0001;
  localparam logic [15:0] FE1 = PC_OE | MAR_WE;
  localparam logic [15:0] FE2 = RAM_OE | IR_WE | PC_INC;

  logic [15:0] act;
  assign act = {pc_oe, pc_inc, pc_load, mar_we, ram_oe, ram_we, ir_we, ir_oe, breg_we,
                alu_oe, alu_sub, acc_oe, acc_we, acc_load, out_we, halted};

  typedef struct {
    logic rst, run, pm, ps;
    logic [3:0] opc;
    logic az;
    logic [3:0] st;
    logic [15:0] strb;
  } vec_t;

  typedef struct {
    int idx;
    logic [3:0] st;
    logic [15:0] strb;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic v(input logic r, input logic rn, input logic pm, input logic ps,
                   input logic [3:0] opc, input logic az, input logic [3:0] st, input logic [15:0] strb);
    vec_t t;
    t.rst = r; t.run = rn; t.pm = pm; t.ps = ps; t.opc = opc; t.az = az; t.st = st; t.strb = strb;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_invariants(input string tag);
    check({tag, " bus_drivers_onehot"}, int'($countones({pc_oe, ram_oe, ir_oe, alu_oe}) <= 1), 1);
    check({tag, " acc_we_vs_load"}, int'(acc_we & acc_load), 0);
    check({tag, " ram_we_vs_oe"}, int'(ram_we & ram_oe), 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int cyc, pulses;
    RESET = 1'b1; run = 1'b1; prog_mode = 1'b0; prog_strobe = 1'b0; opcode = 4'h0; acc_zero = 1'b0;
    tick();

    // reset held with run high, then fetch
    v(1,1,0,0,4'h3,0, 0, 16'h0);
    v(0,1,0,0,4'h3,0, 0, 16'h0);
    // ADD
    v(0,1,0,0,4'h3,0, 2, FE1);
    v(0,1,0,0,4'h3,0, 3, FE2);
    v(0,1,0,0,4'h3,0, 4, 16'h0);
    v(0,1,0,0,4'h3,0, 5, IR_OE | MAR_WE);
    v(0,1,0,0,4'h3,0, 6, RAM_OE | BREG_WE);
    v(0,1,0,0,4'h3,0, 7, ALU_OE | ACC_WE);
    // SUB
    v(0,1,0,0,4'h4,0, 2, FE1);
    v(0,1,0,0,4'h4,0, 3, FE2);
    v(0,1,0,0,4'h4,0, 4, 16'h0);
    v(0,1,0,0,4'h4,0, 5, IR_OE | MAR_WE);
    v(0,1,0,0,4'h4,0, 6, RAM_OE | BREG_WE);
    v(0,1,0,0,4'h4,0, 7, ALU_OE | ACC_WE | ALU_SUB);
    // STA, run dropped in E1
    v(0,1,0,0,4'h2,0, 2, FE1);
    v(0,1,0,0,4'h2,0, 3, FE2);
    v(0,1,0,0,4'h2,0, 4, 16'h0);
    v(0,0,0,0,4'h2,0, 5, IR_OE | MAR_WE | ACC_OE);
    v(0,0,0,0,4'h2,0, 6, RAM_WE);
    v(0,0,0,0,4'h2,0, 0, 16'h0);
    // JZ taken, JZ not taken, then NOP
    v(0,1,0,0,4'h6,1, 0, 16'h0);
    v(0,1,0,0,4'h6,1, 2, FE1);
    v(0,1,0,0,4'h6,1, 3, FE2);
    v(0,1,0,0,4'h6,1, 4, 16'h0);
    v(0,1,0,0,4'h6,1, 5, IR_OE | PC_LOAD);
    v(0,1,0,0,4'h6,0, 2, FE1);
    v(0,1,0,0,4'h6,0, 3, FE2);
    v(0,1,0,0,4'h6,0, 4, 16'h0);
    v(0,1,0,0,4'h6,0, 5, IR_OE);
    v(0,1,0,0,4'h0,0, 2, FE1);
    v(0,1,0,0,4'h0,0, 3, FE2);
    v(0,1,0,0,4'h0,0, 4, 16'h0);
    // LDA with reset during E2
    v(0,1,0,0,4'h1,0, 2, FE1);
    v(0,1,0,0,4'h1,0, 3, FE2);
    v(0,1,0,0,4'h1,0, 4, 16'h0);
    v(0,1,0,0,4'h1,0, 5, IR_OE | MAR_WE);
    v(1,1,0,0,4'h1,0, 6, RAM_OE | ACC_WE);
    v(0,0,0,0,4'h1,0, 0, 16'h0);
    // JMP, OUT, undefined 0xE, HLT
    v(0,1,0,0,4'h5,0, 0, 16'h0);
    v(0,1,0,0,4'h5,0, 2, FE1);
    v(0,1,0,0,4'h5,0, 3, FE2);
    v(0,1,0,0,4'h5,0, 4, 16'h0);
    v(0,1,0,0,4'h5,0, 5, IR_OE | PC_LOAD);
    v(0,1,0,0,4'h7,0, 2, FE1);
    v(0,1,0,0,4'h7,0, 3, FE2);
    v(0,1,0,0,4'h7,0, 4, 16'h0);
    v(0,1,0,0,4'h7,0, 5, ACC_OE);
    v(0,1,0,0,4'h7,0, 6, OUT_WE);
    v(0,1,0,0,4'hE,0, 2, FE1);
    v(0,1,0,0,4'hE,0, 3, FE2);
    v(0,1,0,0,4'hE,0, 4, 16'h0);
    v(0,1,0,0,4'hF,0, 2, FE1);
    v(0,1,0,0,4'hF,0, 3, FE2);
    v(0,1,0,0,4'hF,0, 4, 16'h0);
    v(0,1,0,0,4'hF,0, 8, HALTED);
    v(0,1,0,0,4'hF,0, 8, HALTED);
    v(0,0,0,0,4'hF,0, 8, HALTED);
    v(0,0,0,0,4'hF,0, 0, 16'h0);
    // programmer access wins over run; three strobes
    v(0,1,1,0,4'h0,0, 0, 16'h0);
    v(0,1,1,1,4'h0,0, 1, ACC_LOAD);
    v(0,1,1,0,4'h0,0, 1, 16'h0);
    v(0,1,1,1,4'h0,0, 1, ACC_LOAD);
    v(0,1,1,0,4'h0,0, 1, 16'h0);
    v(0,1,1,1,4'h0,0, 1, ACC_LOAD);
    v(0,0,0,0,4'h0,0, 1, 16'h0);
    v(0,0,0,0,4'h0,0, 0, 16'h0);
    // prog_mode during fetch is ignored
    v(0,1,0,0,4'h0,0, 0, 16'h0);
    v(0,1,0,0,4'h0,0, 2, FE1);
    v(0,1,1,1,4'h0,0, 3, FE2);
    v(0,0,1,1,4'h0,0, 4, 16'h0);
    v(0,0,0,0,4'h0,0, 0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      RESET = vecs[i].rst; run = vecs[i].run; prog_mode = vecs[i].pm;
      prog_strobe = vecs[i].ps; opcode = vecs[i].opc; acc_zero = vecs[i].az;
      e.idx = i; e.st = vecs[i].st; e.strb = vecs[i].strb;
      sb.push_back(e);
      @(negedge CLK);
      e = sb.pop_front();
      check($sformatf("vec%0d state", e.idx), int'(state), int'(e.st));
      check($sformatf("vec%0d strobes", e.idx), int'(act), int'(e.strb));
      check_invariants($sformatf("vec%0d", e.idx));
      tick();
    end

    // HLT reaches HALT four clocks after leaving IDLE (F1, F2, DEC, HALT)
    RESET = 1'b0; prog_mode = 1'b0; prog_strobe = 1'b0; opcode = 4'hF; run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 20) begin
      tick();
      cyc++;
    end
    check("hlt_latency", cyc, 4);
    repeat (3) tick();
    check("halt_hold", int'(halted), 1);
    run = 1'b0;
    tick();
    check("halt_exit_state", int'(state), 0);

    // count single-cycle acc_load pulses over a PROG window
    prog_mode = 1'b1;
    tick();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      prog_strobe = (k % 2 == 0) && (k < 6);
      @(negedge CLK);
      if (acc_load) pulses++;
      tick();
    end
    prog_strobe = 1'b0;
    check("prog_pulses", pulses, 3);
    prog_mode = 1'b0;
    tick();
    check("prog_exit_state", int'(state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
